// File: rtl/slow_mem_responder.sv
// slow_mem_responder
//   Line-granular (128-bit) memory model for one cache port. Each request is
//   answered after a fixed LATENCY cycles with a one-cycle mem_ready pulse.
//   A GUARD cycle follows every completion so the cache can drop its request.
//   Protocol violations by the requester raise a sticky proto_err flag.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous active-low reset
//   mem_read   in   1    read request, held until mem_ready
//   mem_write  in   1    write request, held until mem_ready
//   mem_addr   in   28   line address [31:4]
//   mem_wdata  in   128  write line
//   mem_rdata  out  128  read line, valid in the mem_ready cycle of a read
//   mem_ready  out  1    completion pulse, one cycle per transaction
//   proto_err  out  1    sticky protocol-violation flag (cleared by reset)
module slow_mem_responder #(
  parameter int LATENCY     = 8,
  parameter int LINE_ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:4]   mem_addr,
  input  logic [127:0]  mem_wdata,
  output logic [127:0]  mem_rdata,
  output logic          mem_ready,
  output logic          proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_GUARD} state_t;

  // BUSY lasts LATENCY-1 cycles; the counter runs from LATENCY-2 down to 0.
  localparam int         CNT_INIT_I = (LATENCY >= 2) ? (LATENCY - 2) : 0;
  localparam logic [7:0] CNT_INIT   = CNT_INIT_I[7:0];
  localparam bit         LAT1       = (LATENCY == 1);

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [31:4]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic           err_q, err_d;
  logic [127:0]   rdata_q;

  logic [127:0]   mem_array [0:(1 << LINE_ADDR_W) - 1];

  logic                   accept;
  logic                   rd_load;
  logic                   mem_we;
  logic [LINE_ADDR_W-1:0] rd_idx;
  logic [LINE_ADDR_W-1:0] wr_idx;

  assign accept = (state_q == S_IDLE) && (mem_read || mem_write);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = LAT1 ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt_q == 8'd0) state_d = S_DONE;
      S_DONE:  state_d = S_GUARD;
      S_GUARD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    mem_ready = (state_q == S_DONE);
    mem_rdata = rdata_q;
    proto_err = err_q;
  end

  // ---------------------------------------------------- capture / error logic
  always_comb begin
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = CNT_INIT;
      rd_d    = mem_read;
      wr_d    = mem_write;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      if (mem_read && mem_write) err_d = 1'b1;
    end else if (state_q == S_BUSY) begin
      if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
      // Request must stay frozen while the transaction is in flight.
      if ((mem_read != rd_q) || (mem_write != wr_q) ||
          (mem_addr != addr_q) || (mem_wdata != wdata_q)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // ------------------------------------------------------------- line storage
  // The read is performed on the edge that enters DONE so the registered
  // output is valid during the mem_ready cycle. With LATENCY=1 that edge is
  // the accept edge, so the index comes straight from the request inputs.
  // A write wins when both request bits were high.
  assign rd_idx  = (state_q == S_IDLE) ? mem_addr[LINE_ADDR_W+3:4]
                                       : addr_q[LINE_ADDR_W+3:4];
  assign rd_load = (LAT1 && accept && !mem_write) ||
                   ((state_q == S_BUSY) && (cnt_q == 8'd0) && !wr_q);

  // Gating with rst_n discards a write whose DONE cycle coincides with reset.
  assign wr_idx = addr_q[LINE_ADDR_W+3:4];
  assign mem_we = (state_q == S_DONE) && wr_q && rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[wr_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_load) begin
      rdata_q <= mem_array[rd_idx];
    end
  end

endmodule

// File: tb/tb_slow_mem_responder.sv
module tb_slow_mem_responder;

  localparam int L8 = 8;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;
  localparam logic [127:0] D3 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D4 = 128'h44444444_00000000_44444444_00000010;
  localparam logic [127:0] D5 = 128'h55555555_77777777_55555555_77777777;
  localparam logic [127:0] D6 = 128'h66666666_66666666_66666666_66666666;
  localparam logic [127:0] D7 = 128'h77770000_00007777_12345678_9ABCDEF0;
  localparam logic [127:0] D20 = 128'h20202020_20202020_20202020_20202020;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         mem_read, mem_write;
  logic [31:4]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready, proto_err;

  logic         r1, w1;
  logic [31:4]  a1;
  logic [127:0] wd1, rdata1;
  logic         ready1, err1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  slow_mem_responder #(.LATENCY(L8), .LINE_ADDR_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .proto_err(proto_err)
  );

  slow_mem_responder #(.LATENCY(1), .LINE_ADDR_W(10)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(r1), .mem_write(w1),
    .mem_addr(a1), .mem_wdata(wd1),
    .mem_rdata(rdata1), .mem_ready(ready1), .proto_err(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the LATENCY=8 instance, starting in the current
  // cycle (k=0), dropping it when mem_ready is seen. Returns when the
  // responder is back in IDLE. Optionally changes mem_addr at cycle chg_k.
  task automatic run_txn(input logic rd, input logic wr,
                         input logic [31:4] addr, input logic [127:0] wd,
                         input int chg_k, input logic [31:4] chg_addr,
                         output int ready_at, output int ready_cnt,
                         output logic [127:0] rdata_at);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wd;
    ready_at  = -1;
    ready_cnt = 0;
    rdata_at  = 'x;
    for (int k = 1; k <= L8 + 2; k++) begin
      tick();
      if (k == chg_k) mem_addr = chg_addr;
      if (mem_ready === 1'b1) begin
        ready_cnt++;
        ready_at  = k;
        rdata_at  = mem_rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    r1 = 0; w1 = 0; a1 = '0; wd1 = '0;
    repeat (3) tick();
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", mem_ready); end
    n_vec++; if (mem_rdata !== 128'd0) begin n_err++; $display("FAIL rst_rdata got %h want 0", mem_rdata); end
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", proto_err); end
    n_vec++; if (ready1 !== 1'b0) begin n_err++; $display("FAIL rst_ready1 got %b want 0", ready1); end
    n_vec++; if (rdata1 !== 128'd0) begin n_err++; $display("FAIL rst_rdata1 got %h want 0", rdata1); end
    n_vec++; if (err1 !== 1'b0) begin n_err++; $display("FAIL rst_err1 got %b want 0", err1); end
    rst_n = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_latency1();
    w1 = 1; a1 = 28'h9; wd1 = D7;
    tick();
    n_vec++; if (ready1 !== 1'b1) begin n_err++; $display("FAIL lat1_wr_ready got %b want 1", ready1); end
    w1 = 0;
    tick();
    n_vec++; if (ready1 !== 1'b0) begin n_err++; $display("FAIL lat1_guard got %b want 0", ready1); end
    tick();
    r1 = 1;
    n_vec++; if (rdata1 !== 128'd0) begin n_err++; $display("FAIL lat1_rdata_before got %h want 0", rdata1); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_vec++;
      if (ready1 !== (k % 3 == 1)) begin
        n_err++; $display("FAIL lat1_ready k=%0d got %b want %b", k, ready1, (k % 3 == 1));
      end
      n_vec++;
      if (rdata1 !== D7) begin
        n_err++; $display("FAIL lat1_rdata k=%0d got %h want %h", k, rdata1, D7);
      end
    end
    r1 = 0;
    tick(); tick();
    $display("latency1: held read pulses every 3 cycles");
  endtask

  task automatic test_write_read();
    int at, cnt;
    logic [127:0] rd;
    run_txn(1'b0, 1'b1, 28'h0000040, D1, 0, '0, at, cnt, rd);
    n_vec++; if (at !== L8) begin n_err++; $display("FAIL wr_ready_cycle got %0d want %0d", at, L8); end
    n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL wr_ready_count got %0d want 1", cnt); end
    tick();
    run_txn(1'b1, 1'b0, 28'h0000040, '0, 0, '0, at, cnt, rd);
    n_vec++; if (at !== L8) begin n_err++; $display("FAIL rd_ready_cycle got %0d want %0d", at, L8); end
    n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL rd_ready_count got %0d want 1", cnt); end
    n_vec++; if (rd !== D1) begin n_err++; $display("FAIL rd_data got %h want %h", rd, D1); end
    n_vec++; if (mem_rdata !== D1) begin n_err++; $display("FAIL rd_data_hold got %h want %h", mem_rdata, D1); end
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL wr_rd_err got %b want 0", proto_err); end
    $display("write_read: line 0x40 written and read back");
  endtask

  task automatic test_alias();
    int at, cnt;
    logic [127:0] rd;
    run_txn(1'b0, 1'b1, 28'h0000005, D2, 0, '0, at, cnt, rd);
    n_vec++; if (rd !== D1) begin n_err++; $display("FAIL alias_rdata_hold_on_write got %h want %h", rd, D1); end
    run_txn(1'b1, 1'b0, 28'h0000405, '0, 0, '0, at, cnt, rd);
    n_vec++; if (rd !== D2) begin n_err++; $display("FAIL alias_read got %h want %h", rd, D2); end
    $display("alias: 0x405 reads line written at 0x005");
  endtask

  task automatic test_both_high();
    int at, cnt;
    logic [127:0] rd;
    run_txn(1'b1, 1'b1, 28'h0000033, D3, 0, '0, at, cnt, rd);
    n_vec++; if (at !== L8) begin n_err++; $display("FAIL both_ready_cycle got %0d want %0d", at, L8); end
    n_vec++; if (rd !== D2) begin n_err++; $display("FAIL both_rdata_hold got %h want %h", rd, D2); end
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL both_err got %b want 1", proto_err); end
    run_txn(1'b1, 1'b0, 28'h0000033, '0, 0, '0, at, cnt, rd);
    n_vec++; if (rd !== D3) begin n_err++; $display("FAIL both_as_write got %h want %h", rd, D3); end
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL both_err_sticky got %b want 1", proto_err); end
    rst_n = 1'b0;
    tick();
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL both_err_cleared got %b want 0", proto_err); end
    rst_n = 1'b1;
    $display("both_high: executed as write, proto_err sticky until reset");
  endtask

  task automatic test_addr_change();
    int at, cnt;
    logic [127:0] rd;
    run_txn(1'b0, 1'b1, 28'h0000020, D20, 0, '0, at, cnt, rd);
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL chg_err_before got %b want 0", proto_err); end
    run_txn(1'b0, 1'b1, 28'h0000010, D4, 3, 28'h0000020, at, cnt, rd);
    n_vec++; if (at !== L8) begin n_err++; $display("FAIL chg_ready_cycle got %0d want %0d", at, L8); end
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL chg_err got %b want 1", proto_err); end
    run_txn(1'b1, 1'b0, 28'h0000010, '0, 0, '0, at, cnt, rd);
    n_vec++; if (rd !== D4) begin n_err++; $display("FAIL chg_line10 got %h want %h", rd, D4); end
    run_txn(1'b1, 1'b0, 28'h0000020, '0, 0, '0, at, cnt, rd);
    n_vec++; if (rd !== D20) begin n_err++; $display("FAIL chg_line20 got %h want %h", rd, D20); end
    $display("addr_change: captured address used, proto_err set");
  endtask

  task automatic test_reset_mid_busy();
    int at, cnt;
    int pulses;
    logic [127:0] rd;
    run_txn(1'b0, 1'b1, 28'h0000007, D5, 0, '0, at, cnt, rd);
    run_txn(1'b1, 1'b0, 28'h0000007, '0, 0, '0, at, cnt, rd);
    n_vec++; if (rd !== D5) begin n_err++; $display("FAIL rmb_preload got %h want %h", rd, D5); end
    mem_write = 1; mem_addr = 28'h0000007; mem_wdata = D6;
    tick(); tick(); tick();
    rst_n = 1'b0;
    mem_write = 0;
    tick();
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rmb_ready got %b want 0", mem_ready); end
    n_vec++; if (mem_rdata !== 128'd0) begin n_err++; $display("FAIL rmb_rdata got %h want 0", mem_rdata); end
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rmb_err got %b want 0", proto_err); end
    pulses = 0;
    for (int k = 0; k < L8; k++) begin
      if (k == L8 - 1) begin mem_read = 1; mem_addr = 28'h0000007; end
      tick();
      if (mem_ready === 1'b1) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rmb_no_pulse got %0d want 0", pulses); end
    rst_n = 1'b1;
    run_txn(1'b1, 1'b0, 28'h0000007, '0, 0, '0, at, cnt, rd);
    n_vec++; if (at !== L8) begin n_err++; $display("FAIL rmb_held_accept got %0d want %0d", at, L8); end
    n_vec++; if (rd !== D5) begin n_err++; $display("FAIL rmb_line7_kept got %h want %h", rd, D5); end
    $display("reset_mid_busy: write discarded, outputs reset");
  endtask

  initial begin
    test_reset();
    test_latency1();
    test_write_read();
    test_alias();
    test_both_high();
    test_addr_change();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
